// File: rtl/complete_stage_if.sv
// -----------------------------------------------------------------------------
// complete_stage_if
//   Groups the functional-unit completion handshake and the CDB broadcast
//   lanes of the complete stage into one bundle.
//
//   FU side (one slot per functional unit):
//     fu_valid[k]          completion offered by FU k this cycle
//     fu_tag[k]            destination physical-register tag (0 = no dest)
//     fu_result[k]         result value
//     fu_ready[k]          complete stage can take a completion from FU k
//   CDB side (one slot per broadcast lane):
//     complete_dest_tag[j] tag broadcast on lane j, 0 = lane idle
//     complete_value[j]    value paired with complete_dest_tag[j]
//     complete_num         number of non-idle lanes
//
//   Modports: master = FUs plus CDB consumers, slave = complete stage.
// -----------------------------------------------------------------------------
interface complete_stage_if #(
  parameter int N_FU     = 4,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32
);
  localparam int NUM_W = $clog2(N_WAY) + 1;

  logic [N_FU-1:0]                fu_valid;
  logic [N_FU-1:0][CDB_BITS-1:0]  fu_tag;
  logic [N_FU-1:0][XLEN-1:0]      fu_result;
  logic [N_FU-1:0]                fu_ready;

  logic [N_WAY-1:0][CDB_BITS-1:0] complete_dest_tag;
  logic [N_WAY-1:0][XLEN-1:0]     complete_value;
  logic [NUM_W-1:0]               complete_num;

  modport master (
    output fu_valid, fu_tag, fu_result,
    input  fu_ready, complete_dest_tag, complete_value, complete_num
  );

  modport slave (
    input  fu_valid, fu_tag, fu_result,
    output fu_ready, complete_dest_tag, complete_value, complete_num
  );
endinterface

// File: rtl/complete_stage.sv
// -----------------------------------------------------------------------------
// complete_stage
//   Collects completions from N_FU functional units into small per-FU FIFOs
//   and broadcasts up to N_WAY of them per cycle on the common data bus.
//   A round-robin arbiter picks which non-empty FIFOs pop each cycle; the
//   picked heads are packed into the lowest lanes and registered.
//
//   Ports:
//     clock        rising-edge clock for all state
//     reset        synchronous, active-high; beats take_branch and traffic
//     take_branch  mispredict flush: empties FIFOs, idles the lanes
//     bus          complete_stage_if.slave (FU handshake + CDB lanes)
//
//   Latency: pushed at edge t, eligible for grant in the next cycle, visible
//   on the lanes after edge t+1.
// -----------------------------------------------------------------------------
module complete_stage #(
  parameter int N_FU     = 4,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              take_branch,
  complete_stage_if.slave   bus
);

  // Two entries per FU; head/tail are single toggling bits because of this.
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int NUM_W      = $clog2(N_WAY) + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CDB_BITS-1:0]            r_tag   [N_FU][FIFO_DEPTH];
  logic [XLEN-1:0]                r_res   [N_FU][FIFO_DEPTH];
  logic [N_FU-1:0]                r_head;
  logic [N_FU-1:0]                r_tail;
  logic [1:0]                     r_count [N_FU];
  logic [PTR_W-1:0]               r_rr_ptr;

  logic [N_WAY-1:0][CDB_BITS-1:0] r_out_tag;
  logic [N_WAY-1:0][XLEN-1:0]     r_out_val;
  logic [NUM_W-1:0]               r_out_num;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [N_FU-1:0]                w_ready;
  logic [N_FU-1:0]                w_push;
  logic [N_FU-1:0]                w_grant;
  logic [N_WAY-1:0][CDB_BITS-1:0] w_lane_tag;
  logic [N_WAY-1:0][XLEN-1:0]     w_lane_val;
  logic [NUM_W-1:0]               w_num;
  logic [PTR_W-1:0]               w_rr_next;
  logic [N_WAY-1:0]               w_lane_busy;

  // (base + off) mod N_FU, used to walk the FUs starting at the RR pointer.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = {{(32-PTR_W){1'b0}}, base} + off;
    return PTR_W'(s % N_FU);
  endfunction

  // Ready is taken from the registered count only: a full FIFO stays not-ready
  // even in a cycle where it is being popped, which keeps fu_ready free of any
  // path through the arbiter.
  // Tag 0 means "no destination": the handshake completes but nothing is
  // stored. Flush and reset discard whatever is offered in their cycle.
  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_ready = '0;
    w_push  = '0;
    for (int k = 0; k < N_FU; k++) begin
      w_ready[k] = (r_count[k] < 2'(FIFO_DEPTH));
      w_push[k]  = bus.fu_valid[k] && w_ready[k] && (bus.fu_tag[k] != '0)
                   && !take_branch && !reset;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: walk from r_rr_ptr upward (mod N_FU), grant the first
  // N_WAY non-empty FIFOs and pack their heads into lanes 0.. in grant order.
  // Each FIFO is visited once per walk, so it is granted at most once.
  // ---------------------------------------------------------------------------
  always_comb begin : arbiter
    int               n;
    logic [PTR_W-1:0] idx;
    w_grant    = '0;
    w_lane_tag = '0;
    w_lane_val = '0;
    w_num      = '0;
    w_rr_next  = r_rr_ptr;
    n          = 0;
    idx        = '0;
    for (int unsigned i = 0; i < N_FU; i++) begin
      idx = wrap_idx(r_rr_ptr, i);
      if (r_count[idx] != 2'd0 && n < N_WAY) begin
        w_grant[idx] = 1'b1;
        for (int j = 0; j < N_WAY; j++) begin
          if (j == n) begin
            w_lane_tag[j] = r_tag[idx][r_head[idx]];
            w_lane_val[j] = r_res[idx][r_head[idx]];
          end
        end
        n = n + 1;
        // Pointer lands just past the last FIFO served this cycle.
        w_rr_next = wrap_idx(idx, 1);
      end
    end
    w_num = NUM_W'(n);
  end

  // ---------------------------------------------------------------------------
  // FIFO control, RR pointer and output lanes. Reset and flush clear the same
  // state; reset additionally wins because pushes are already gated by it.
  // Grants computed in a flush cycle are dropped because the lanes load zero.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || take_branch) begin
      for (int k = 0; k < N_FU; k++) begin
        r_count[k] <= '0;
      end
      r_head    <= '0;
      r_tail    <= '0;
      r_rr_ptr  <= '0;
      r_out_tag <= '0;
      r_out_val <= '0;
      r_out_num <= '0;
    end else begin
      for (int k = 0; k < N_FU; k++) begin
        if (w_push[k])  r_tail[k] <= ~r_tail[k];
        if (w_grant[k]) r_head[k] <= ~r_head[k];
        // Push and pop together leave the occupancy unchanged.
        unique case ({w_push[k], w_grant[k]})
          2'b10:   r_count[k] <= r_count[k] + 2'd1;
          2'b01:   r_count[k] <= r_count[k] - 2'd1;
          default: r_count[k] <= r_count[k];
        endcase
      end
      r_rr_ptr  <= w_rr_next;
      r_out_tag <= w_lane_tag;
      r_out_val <= w_lane_val;
      r_out_num <= w_num;
    end
  end

  // FIFO payload storage.
  // NOTE: the payload array has no reset; the counts alone decide which slots
  // are live, so stale contents are never read and the RAM stays reset-free.
  always_ff @(posedge clock) begin
    for (int k = 0; k < N_FU; k++) begin
      if (w_push[k]) begin
        r_tag[k][r_tail[k]] <= bus.fu_tag[k];
        r_res[k][r_tail[k]] <= bus.fu_result[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: lanes come straight from registers.
  // ---------------------------------------------------------------------------
  assign bus.fu_ready          = w_ready;
  assign bus.complete_dest_tag = r_out_tag;
  assign bus.complete_value    = r_out_val;
  assign bus.complete_num      = r_out_num;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lane_busy = '0;
    for (int j = 0; j < N_WAY; j++) begin
      w_lane_busy[j] = (r_out_tag[j] != '0);
    end
  end

  // Stored tags are never 0, so busy lanes and the lane count must agree.
  a_num_matches_lanes: assert property (@(posedge clock) disable iff (reset)
    r_out_num == NUM_W'($countones(w_lane_busy)));

  for (genvar k = 0; k < N_FU; k++) begin : g_fifo_chk
    a_count_bound: assert property (@(posedge clock) disable iff (reset)
      r_count[k] <= 2'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_complete_stage.sv
// -----------------------------------------------------------------------------
// tb_complete_stage
//   Directed bench for complete_stage with a scoreboard: stimulus pushes the
//   expected broadcast of each output cycle into a queue, and a monitor on the
//   falling edge pops and compares whenever the lanes are non-idle.
// -----------------------------------------------------------------------------
module tb_complete_stage;

  localparam int N_FU     = 4;
  localparam int N_WAY    = 2;
  localparam int CDB_BITS = 6;
  localparam int XLEN     = 32;

  logic clock       = 1'b0;
  logic reset       = 1'b1;
  logic take_branch = 1'b0;

  complete_stage_if #(.N_FU(N_FU), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS),
                      .XLEN(XLEN)) bus ();

  complete_stage #(.N_FU(N_FU), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS),
                   .XLEN(XLEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .take_branch (take_branch),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  // One output cycle as seen on the CDB.
  typedef struct packed {
    logic [1:0]                     num;
    logic [N_WAY-1:0][CDB_BITS-1:0] tag;
    logic [N_WAY-1:0][XLEN-1:0]     val;
  } out_t;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] vv(input int t);
    return 32'h0000_1000 + 32'(t);
  endfunction

  function automatic out_t mk(input int n, input int t0, input logic [31:0] v0,
                              input int t1, input logic [31:0] v1);
    out_t o;
    o.num    = 2'(n);
    o.tag[0] = 6'(t0);
    o.val[0] = v0;
    o.tag[1] = 6'(t1);
    o.val[1] = v1;
    return o;
  endfunction

  function automatic logic [3:0][5:0] tg4(input int a0, input int a1,
                                          input int a2, input int a3);
    logic [3:0][5:0] t;
    t[0] = 6'(a0);
    t[1] = 6'(a1);
    t[2] = 6'(a2);
    t[3] = 6'(a3);
    return t;
  endfunction

  function automatic logic [3:0][31:0] rs(input logic [3:0][5:0] t);
    logic [3:0][31:0] r;
    for (int k = 0; k < 4; k++) r[k] = vv(int'(t[k]));
    return r;
  endfunction

  // Apply inputs, let one rising edge pass, return 1 time unit after it.
  task automatic drive(input logic [3:0] v, input logic [3:0][5:0] t,
                       input logic [3:0][31:0] r, input logic br);
    bus.fu_valid  = v;
    bus.fu_tag    = t;
    bus.fu_result = r;
    take_branch   = br;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0000, tg4(0, 0, 0, 0), '0, 1'b0);
  endtask

  task automatic check_quiet(input string name);
    check({name, " num"},  128'(bus.complete_num),      128'(0));
    check({name, " tags"}, 128'(bus.complete_dest_tag), 128'(0));
    check({name, " vals"}, 128'(bus.complete_value),    128'(0));
  endtask

  // Monitor: every non-idle cycle must match the next expected broadcast;
  // idle cycles must carry zero values as well as zero tags.
  always @(negedge clock) begin
    out_t act;
    out_t e;
    act.num = bus.complete_num;
    act.tag = bus.complete_dest_tag;
    act.val = bus.complete_value;
    if (act.num != 2'd0 || act.tag != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected broadcast", 128'(act), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("broadcast", 128'(act), 128'(e));
      end
    end else begin
      check("idle lane values", 128'(act.val), 128'(0));
    end
  end

  initial begin
    bus.fu_valid  = '0;
    bus.fu_tag    = '0;
    bus.fu_result = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("ready after reset", 128'(bus.fu_ready), 128'(4'hF));
    check_quiet("after reset");

    // Single completion on FU0: visible after t+1, idle after t+2
    exp_q.push_back(mk(1, 5, 32'hAA, 0, 0));
    drive(4'b0001, tg4(5, 0, 0, 0), {96'h0, 32'hAA}, 1'b0);
    idle(1);
    check("single lane0 tag", 128'(bus.complete_dest_tag[0]), 128'(5));
    check("single num",       128'(bus.complete_num),         128'(1));
    idle(1);
    check_quiet("single drained");

    // Flush with empty FIFOs just to park the RR pointer at 0
    drive(4'b0000, tg4(0, 0, 0, 0), '0, 1'b1);
    check("ready after flush", 128'(bus.fu_ready), 128'(4'hF));

    // Round-robin over all four FUs from pointer 0
    exp_q.push_back(mk(2, 1, vv(1), 2, vv(2)));
    exp_q.push_back(mk(2, 3, vv(3), 4, vv(4)));
    drive(4'b1111, tg4(1, 2, 3, 4), rs(tg4(1, 2, 3, 4)), 1'b0);
    idle(4);

    // Backpressure on FU2 while FU0/FU1/FU3 stay busy
    exp_q.push_back(mk(2, 20, vv(20), 21, vv(21)));
    exp_q.push_back(mk(2, 7,  vv(7),  23, vv(23)));
    exp_q.push_back(mk(2, 30, vv(30), 31, vv(31)));
    exp_q.push_back(mk(2, 8,  vv(8),  33, vv(33)));
    exp_q.push_back(mk(1, 9,  vv(9),  0,  0));
    drive(4'b1111, tg4(20, 21, 7, 23), rs(tg4(20, 21, 7, 23)), 1'b0);
    drive(4'b0111, tg4(30, 31, 8, 0),  rs(tg4(30, 31, 8, 0)),  1'b0);
    check("FU2 full after two pushes", 128'(bus.fu_ready[2]), 128'(0));
    check("FU3 ready while FU2 full",  128'(bus.fu_ready[3]), 128'(1));
    drive(4'b1100, tg4(0, 0, 9, 33),   rs(tg4(0, 0, 9, 33)),   1'b0);
    check("FU2 ready after its grant", 128'(bus.fu_ready[2]), 128'(1));
    drive(4'b0100, tg4(0, 0, 9, 0),    rs(tg4(0, 0, 9, 0)),    1'b0);
    idle(5);

    // Flush mid-stream: 10..13 must never appear, 14 goes through
    drive(4'b0111, tg4(10, 11, 12, 0), rs(tg4(10, 11, 12, 0)), 1'b0);
    drive(4'b1000, tg4(0, 0, 0, 13),   rs(tg4(0, 0, 0, 13)),   1'b1);
    check_quiet("after flush");
    check("ready after mid flush", 128'(bus.fu_ready), 128'(4'hF));
    exp_q.push_back(mk(1, 14, vv(14), 0, 0));
    drive(4'b0010, tg4(0, 14, 0, 0), rs(tg4(0, 14, 0, 0)), 1'b0);
    idle(1);
    check("post-flush lane0 tag", 128'(bus.complete_dest_tag[0]), 128'(14));
    idle(3);

    // Tag 0 on FU1 is accepted and dropped
    drive(4'b0010, tg4(0, 0, 0, 0), '0, 1'b0);
    check("tag0 ready 1st", 128'(bus.fu_ready), 128'(4'hF));
    drive(4'b0010, tg4(0, 0, 0, 0), '0, 1'b0);
    check("tag0 ready 2nd", 128'(bus.fu_ready), 128'(4'hF));
    idle(3);

    // Reset during traffic together with take_branch
    drive(4'b1111, tg4(50, 51, 52, 53), rs(tg4(50, 51, 52, 53)), 1'b0);
    reset = 1'b1;
    drive(4'b1111, tg4(60, 61, 62, 63), rs(tg4(60, 61, 62, 63)), 1'b1);
    reset = 1'b0;
    take_branch = 1'b0;
    check_quiet("after traffic reset");
    check("ready after traffic reset", 128'(bus.fu_ready), 128'(4'hF));
    // Pointer back at 0: FU0 must be packed ahead of FU3
    exp_q.push_back(mk(2, 40, vv(40), 43, vv(43)));
    drive(4'b1001, tg4(40, 0, 0, 43), rs(tg4(40, 0, 0, 43)), 1'b0);
    idle(4);

    check("scoreboard drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/complete_stage.md
COMPLETE_STAGE -- requirements
Module: complete_stage

Interface
REQ-001 The block SHALL have these parameters:
- N_FU, default 4: number of functional-unit completion ports.
- N_WAY, default 2: number of CDB broadcast lanes per cycle.
- CDB_BITS, default 6: physical-register tag width.
- XLEN, default 32: result data width.
- FIFO_DEPTH, fixed at 2: entries per FU buffer.

REQ-002 The block SHALL have these ports, clock and reset first:
- clock, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high.
- take_branch, input, 1: mispredict flush from the ex stage.
- fu_valid, input, [N_FU]: per FU, a completion is offered this cycle.
- fu_tag, input, [N_FU][CDB_BITS]: destination physical-register tag of the offered completion.
- fu_result, input, [N_FU][XLEN]: result value of the offered completion.
- fu_ready, output, [N_FU]: per FU, the block can accept a completion this cycle.
- complete_dest_tag, output, [N_WAY][CDB_BITS]: tags broadcast to the ROB, map table and RS; 0 = lane idle.
- complete_value, output, [N_WAY][XLEN]: values paired with complete_dest_tag.
- complete_num, output, clog2(N_WAY)+1 bits: count of non-idle lanes this cycle.

Function
REQ-003 Each FU port SHALL own a 2-entry FIFO holding {tag, result}, plus a 2-bit occupancy count.
REQ-004 fu_ready[k] SHALL equal (count[k] < 2) and SHALL depend only on registered state; there is no pop-bypass, so a full FIFO deasserts ready even when it is popped in the same cycle.
REQ-005 A push to FIFO k SHALL occur exactly when fu_valid[k] && fu_ready[k] && fu_tag[k] != 0 && !take_branch && !reset.
- A completion offered with tag 0 SHALL be accepted (handshake completes) and discarded.
REQ-006 Each cycle, the round-robin arbiter SHALL grant up to N_WAY distinct non-empty FIFOs.
- Search order starts at pointer rr_ptr and proceeds in increasing index order, modulo N_FU.
- Each granted FIFO pops its head entry.
REQ-007 Granted entries SHALL be registered into complete_dest_tag/complete_value.
- Lanes are filled from lane 0 upward in grant order, with no gaps.
- Unused lanes SHALL register tag 0 and value 0.
- complete_num SHALL register the number of grants.
REQ-008 Latency: an entry pushed at edge t SHALL be eligible for grant in the cycle after edge t, and SHALL appear on the outputs after edge t+1 at the earliest (one cycle of buffering plus one registered output stage).
REQ-009 After any cycle with at least one grant, rr_ptr SHALL become (index of the last granted FIFO + 1) mod N_FU; with zero grants, rr_ptr SHALL hold.
REQ-010 A FIFO SHALL support a simultaneous push and pop: count is unchanged, the head advances, and the new entry lands at the tail.
REQ-011 Entries within one FIFO SHALL be broadcast in push order, and a FIFO SHALL be granted at most once per cycle.
REQ-012 Flush: when take_branch is 1 at an edge, the block SHALL do all of the following at that edge:
- Zero every FIFO count.
- Register all output lanes to tag 0 / value 0 / complete_num 0.
- Reset rr_ptr to 0.
- Drop that cycle's pushes; no grant issued in that cycle is broadcast.
REQ-013 Every output lane SHALL be driven only from registers; complete_dest_tag SHALL never carry a nonzero tag that was not pushed after the most recent reset or flush.
REQ-014 If all FIFOs are empty, all lanes SHALL be idle (tag 0) in the next cycle.
- With more than N_WAY non-empty FIFOs, excess FIFOs SHALL wait; round-robin guarantees each waits at most ceil(N_FU/N_WAY)-1 grant cycles.

Reset
REQ-015 At an edge with reset=1, the block SHALL set all FIFO counts and head/tail pointers to 0, rr_ptr to 0, and complete_dest_tag, complete_value and complete_num to 0.
REQ-016 In the cycle after reset, fu_ready SHALL be all ones.
REQ-017 Reset SHALL take priority over take_branch and over any push or grant in the same cycle; an in-flight push at reset is lost.

Verification
REQ-018 Single completion:
- Stimulus: fu_valid=4'b0001, fu_tag[0]=5, fu_result[0]=32'hAA for one cycle at edge t.
- Response: after edge t+1, lane0 tag=5, value=32'hAA, lane1 tag=0, complete_num=1; after edge t+2, all lanes idle.
REQ-019 Round-robin over all FUs:
- Stimulus: all four FUs push tags 1,2,3,4 at the same edge, rr_ptr=0.
- Response: the next output cycle shows lanes {1,2}, the following shows {3,4}; rr_ptr returns to 0.
REQ-020 Backpressure:
- Stimulus: FU2 holds fu_valid=1 for 3 consecutive cycles with tags 7,8,9 while the arbiter is starved. Starving is forced by keeping FU0, FU1 and FU3 continuously non-empty and rr_ptr such that FU2 loses.
- Response: fu_ready[2]=0 after the second push; tag 9 is accepted only once FU2 has been granted; order at output is 7,8,9.
REQ-021 Tag-0 drop:
- Stimulus: fu_valid[1]=1, fu_tag[1]=0.
- Response: fu_ready[1] stays 1, count[1] stays 0, no broadcast.
REQ-022 Flush mid-stream:
- Stimulus: FIFOs hold tags 10,11,12, and take_branch=1 together with a new push of tag 13.
- Response: after that edge all lanes are 0 and complete_num=0; tags 10 through 13 never appear; the following push of tag 14 broadcasts normally two edges later.
REQ-023 Reset during traffic:
- Stimulus: reset=1 for one cycle while all FIFOs are full and take_branch=1.
- Response: all outputs 0, fu_ready=4'b1111 next cycle, rr_ptr=0.
